// File: rtl/split_route_pkg.sv
// ---------------------------------------------------------------------------
// split_route_pkg : flit field positions, type/route encodings, FSM states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package split_route_pkg;

  localparam int FLIT_W  = 11;
  localparam int TYPE_HI = 10;
  localparam int TYPE_LO = 9;
  localparam int DX_HI   = 8;
  localparam int DX_LO   = 7;
  localparam int DY_HI   = 6;
  localparam int DY_LO   = 5;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ROUTE_XP = 2'b00,
    ROUTE_XM = 2'b01,
    ROUTE_YP = 2'b10,
    ROUTE_YM = 2'b11
  } route_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PKT  = 2'b01,
    ST_DROP = 2'b10
  } state_e;

  // Dimension-ordered XY route; the dest == node case is filtered by the caller.
  function automatic route_e xy_route(input logic [1:0] dx, input logic [1:0] dy,
                                      input logic [1:0] mx, input logic [1:0] my);
    if (dx > mx)      return ROUTE_XP;
    else if (dx < mx) return ROUTE_XM;
    else if (dy > my) return ROUTE_YP;
    else              return ROUTE_YM;
  endfunction

endpackage

`default_nettype wire

// File: rtl/split_route_fifo.sv
// ---------------------------------------------------------------------------
// split_route_fifo : first-word-fall-through flit FIFO, power-of-2 depth
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module split_route_fifo
  import split_route_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FLIT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

`default_nettype wire

// File: rtl/split_route_feeder.sv
// ---------------------------------------------------------------------------
// split_route_feeder : buffers flits and drives XY route control to a 4-way split
// Optional drop counter output enabled by SPLIT_ROUTE_DROP_CNT_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module split_route_feeder
  import split_route_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [10:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [10:0]            out_data,
  output logic [1:0]             out_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   drop_err,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef SPLIT_ROUTE_DROP_CNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam logic [1:0] NODE_X = 2'(MY_X);
  localparam logic [1:0] NODE_Y = 2'(MY_Y);

  logic [FLIT_W-1:0] front;
  logic              fifo_full, fifo_empty, push, pop, drop;
  logic              ready_en_q, ready_en_d;
  state_e            state_q, state_d;
  logic [1:0]        route_q, route_d;
  flit_type_e        ftype;
  logic              head_like, is_local;
  route_e            calc_route;

  // Keeps in_ready low for the first cycle after reset release.
  assign ready_en_d = 1'b1;
  assign in_ready   = ready_en_q & ~fifo_full;
  assign push       = in_valid & in_ready;

  split_route_fifo #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (front),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ftype      = flit_type_e'(front[TYPE_HI:TYPE_LO]);
  assign head_like  = (ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE);
  assign is_local   = (front[DX_HI:DX_LO] == NODE_X) && (front[DY_HI:DY_LO] == NODE_Y);
  assign calc_route = xy_route(front[DX_HI:DX_LO], front[DY_HI:DY_LO], NODE_X, NODE_Y);
  assign out_data   = front;

  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    out_valid = 1'b0;
    out_ctrl  = route_q;
    pop       = 1'b0;
    drop      = 1'b0;
    if (!fifo_empty) begin
      case (state_q)
        ST_IDLE: begin
          if (!head_like) begin
            pop  = 1'b1;
            drop = 1'b1;
          end else if (is_local) begin
            pop  = 1'b1;
            drop = 1'b1;
            if (ftype == FLIT_HEAD) state_d = ST_DROP;
          end else begin
            out_valid = 1'b1;
            out_ctrl  = calc_route;
            if (out_ready) begin
              pop     = 1'b1;
              route_d = calc_route;
              if (ftype == FLIT_HEAD) state_d = ST_PKT;
            end
          end
        end
        ST_PKT: begin
          // A new head ends the current packet; it is routed from IDLE next cycle.
          if (head_like) begin
            state_d = ST_IDLE;
          end else begin
            out_valid = 1'b1;
            if (out_ready) begin
              pop = 1'b1;
              if (ftype == FLIT_TAIL) state_d = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (head_like) begin
            state_d = ST_IDLE;
          end else begin
            pop  = 1'b1;
            drop = 1'b1;
            if (ftype == FLIT_TAIL) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      route_q    <= ROUTE_XP;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign drop_err = drop;

`ifdef SPLIT_ROUTE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= 8'd0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_split_route_feeder.sv
// ---------------------------------------------------------------------------
// tb_split_route_feeder : directed self-checking bench, node (1,1), DEPTH 4
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_split_route_feeder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] out_data;
  logic [1:0]  out_ctrl;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        drop_err;
  logic [2:0]  fifo_count;
`ifdef SPLIT_ROUTE_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [12:0] xq[$];
  int drops = 0;
  int x_base = 0;
  int drop_base = 0;

  always #5 clk = ~clk;

  split_route_feeder #(.DEPTH(DEPTH), .MY_X(1), .MY_Y(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_err   (drop_err),
    .fifo_count (fifo_count)
`ifdef SPLIT_ROUTE_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  // Inputs only change just after posedge, so negedge values hold through the next edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) xq.push_back({out_ctrl, out_data});
      if (drop_err) drops <= drops + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_xfer(input string tag, input int idx, input logic [1:0] c, input logic [10:0] d);
    logic [12:0] obs;
    obs = (x_base + idx < xq.size()) ? xq[x_base + idx] : 13'h1FFF;
    check_val(tag, {19'd0, obs}, {19'd0, c, d});
  endtask

  task automatic do_reset(input bit check_regs);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    if (check_regs) begin
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_drop_err", drop_err, 0);
      check_val("rst_fifo_count", fifo_count, 0);
      check_val("rst_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    if (check_regs) check_val("rel_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    if (check_regs) check_val("rel_in_ready_high", in_ready, 1);
    x_base    = xq.size();
    drop_base = drops;
  endtask

  task automatic send(input logic [10:0] f);
    int n;
    n = 0;
    in_data  = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_val("send_timeout_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single flit to (3,0): route X+, one-cycle fall-through latency.
    do_reset(1'b1);
    in_data  = 11'h780;
    in_valid = 1'b1;
    @(negedge clk);
    check_val("t1_no_valid_before_push", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("t1_valid_after_push", out_valid, 1);
    check_val("t1_ctrl", out_ctrl, 2'b00);
    idle(4);
    check_val("t1_xfers", xq.size() - x_base, 1);
    check_xfer("t1_xfer0", 0, 2'b00, 11'h780);
    check_val("t1_idle_valid", out_valid, 0);

    // Head to (1,0), two bodies, tail: all Y-.
    do_reset(1'b0);
    send(11'h280); send(11'h011); send(11'h022); send(11'h433);
    idle(6);
    check_val("t2_xfers", xq.size() - x_base, 4);
    check_xfer("t2_xfer0", 0, 2'b11, 11'h280);
    check_xfer("t2_xfer1", 1, 2'b11, 11'h011);
    check_xfer("t2_xfer2", 2, 2'b11, 11'h022);
    check_xfer("t2_xfer3", 3, 2'b11, 11'h433);
    check_val("t2_count", fifo_count, 0);

    // Packet addressed to this node is discarded.
    do_reset(1'b0);
    send(11'h2A0); send(11'h055); send(11'h466);
    idle(6);
    check_val("t3_xfers", xq.size() - x_base, 0);
    check_val("t3_drops", drops - drop_base, 3);
`ifdef SPLIT_ROUTE_DROP_CNT_EN
    check_val("t3_drop_cnt", drop_cnt, 3);
`endif

    // Backpressure fills the FIFO; output held stable.
    do_reset(1'b0);
    out_ready = 1'b0;
    send(11'h320); send(11'h001); send(11'h002); send(11'h003);
    check_val("t4_count_full", fifo_count, 4);
    check_val("t4_in_ready_low", in_ready, 0);
    check_val("t4_valid", out_valid, 1);
    check_val("t4_data", out_data, 11'h320);
    check_val("t4_ctrl", out_ctrl, 2'b00);
    in_data  = 11'h404;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_val("t4_count_hold", fifo_count, 4);
    check_val("t4_data_hold", out_data, 11'h320);
    check_val("t4_in_ready_hold", in_ready, 0);
    out_ready = 1'b1;
    send(11'h404);
    idle(8);
    check_val("t4_xfers", xq.size() - x_base, 5);
    check_xfer("t4_xfer0", 0, 2'b00, 11'h320);
    check_xfer("t4_xfer1", 1, 2'b00, 11'h001);
    check_xfer("t4_xfer2", 2, 2'b00, 11'h002);
    check_xfer("t4_xfer3", 3, 2'b00, 11'h003);
    check_xfer("t4_xfer4", 4, 2'b00, 11'h404);

    // Reset mid-packet: a following body has no open packet and is dropped.
    do_reset(1'b0);
    send(11'h320);
    idle(2);
    check_val("t5_head_xfer", xq.size() - x_base, 1);
    reset_n = 1'b0;
    #2;
    check_val("t5_rst_valid", out_valid, 0);
    check_val("t5_rst_count", fifo_count, 0);
    check_val("t5_rst_in_ready", in_ready, 0);
    check_val("t5_rst_drop_err", drop_err, 0);
`ifdef SPLIT_ROUTE_DROP_CNT_EN
    check_val("t5_rst_drop_cnt", drop_cnt, 0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    x_base    = xq.size();
    drop_base = drops;
    send(11'h011);
    idle(4);
    check_val("t5_xfers", xq.size() - x_base, 0);
    check_val("t5_drops", drops - drop_base, 1);

    // New head without a tail terminates the previous packet.
    do_reset(1'b0);
    send(11'h220); send(11'h320); send(11'h477);
    idle(8);
    check_val("t6_xfers", xq.size() - x_base, 3);
    check_xfer("t6_xfer0", 0, 2'b01, 11'h220);
    check_xfer("t6_xfer1", 1, 2'b00, 11'h320);
    check_xfer("t6_xfer2", 2, 2'b00, 11'h477);
    check_val("t6_drops", drops - drop_base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
